// File: rtl/mem_lsu_pkg.sv
// Shared CPU defines for the load/store unit: ls_sel bit positions, bus size
// codes, LSU FSM state encoding and small address helpers.
package mem_lsu_pkg;

  localparam int LS_SEL_STORE    = 3;
  localparam int LS_SEL_UNSIGNED = 2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // The reserved size code behaves as a word access.
  function automatic logic [1:0] bus_size(input logic [1:0] sel_size);
    return (sel_size == SIZE_RSVD) ? SIZE_WORD : sel_size;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) ||
           ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational data steering: load lane extract with sign/zero extension,
// and store lane replication.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  input  logic [1:0]  st_size,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = rdata[{ld_addr_lo, 3'b000} +: 8];
    ld_half = rdata[{ld_addr_lo[1], 4'b0000} +: 16];
    ld_data = rdata;
    case (ld_size)
      SIZE_BYTE: ld_data = ld_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = ld_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default:   ld_data = rdata;
    endcase
  end

  always_comb begin
    st_data = wdata;
    case (st_size)
      SIZE_BYTE: st_data = {4{wdata[7:0]}};
      SIZE_HALF: st_data = {2{wdata[15:0]}};
      default:   st_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one bus transaction at a time, stalls the
// pipeline while it is outstanding and returns the aligned load result.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ls_ena,
  input  logic [3:0]  ls_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_stall,
  output logic        mem_adel,
  output logic        mem_ades,
  output lsu_state_t  state_dbg
);

  // Bus handshake: data_req stays high with stable addr/size/wr/wdata until the
  // cycle data_addr_ok is seen; data_data_ok (with data_rdata for loads) closes
  // the transaction and may coincide with data_addr_ok.

  lsu_state_t  state_q, state_d;
  logic        killed_q, killed_d;
  logic        launch, capture;
  logic [31:0] req_addr_q, req_wdata_q, mem_rdata_q;
  logic [1:0]  req_size_q;
  logic        req_wr_q, req_unsigned_q;

  logic [1:0]  cur_size;
  logic        cur_store, cur_misaligned;
  logic [31:0] ld_data, st_data;

  assign cur_size       = bus_size(ls_sel[1:0]);
  assign cur_store      = ls_sel[LS_SEL_STORE];
  assign cur_misaligned = misaligned(cur_size, addr[1:0]);

  lsu_align u_align (
    .ld_size     (req_size_q),
    .ld_unsigned (req_unsigned_q),
    .ld_addr_lo  (req_addr_q[1:0]),
    .rdata       (data_rdata),
    .st_size     (cur_size),
    .wdata       (wdata),
    .ld_data     (ld_data),
    .st_data     (st_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      killed_q       <= 1'b0;
      req_addr_q     <= 32'h0;
      req_wdata_q    <= 32'h0;
      req_size_q     <= SIZE_BYTE;
      req_wr_q       <= 1'b0;
      req_unsigned_q <= 1'b0;
      mem_rdata_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      if (launch) begin
        req_addr_q     <= addr;
        req_wdata_q    <= st_data;
        req_size_q     <= cur_size;
        req_wr_q       <= cur_store;
        req_unsigned_q <= ls_sel[LS_SEL_UNSIGNED];
      end
      if (capture && !req_wr_q) begin
        mem_rdata_q <= ld_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    killed_d  = killed_q;
    launch    = 1'b0;
    capture   = 1'b0;
    data_req  = 1'b0;
    mem_stall = 1'b0;
    mem_valid = 1'b0;
    mem_adel  = 1'b0;
    mem_ades  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        killed_d = 1'b0;
        if (!rst && ls_ena && !flush) begin
          if (cur_misaligned) begin
            mem_adel = !cur_store;
            mem_ades = cur_store;
          end else begin
            mem_stall = 1'b1;
            launch    = 1'b1;
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        data_req  = 1'b1;
        mem_stall = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            capture = !flush;
            state_d = flush ? ST_IDLE : ST_DONE;
          end else begin
            // Already accepted by the bus: the response must still be absorbed.
            killed_d = flush;
            state_d  = ST_WAIT;
          end
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        mem_stall = 1'b1;
        if (flush) killed_d = 1'b1;
        if (data_data_ok) begin
          if (killed_q || flush) begin
            killed_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            capture = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        mem_valid = !req_wr_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_wr    = req_wr_q;
  assign data_size  = req_size_q;
  assign data_addr  = req_addr_q;
  assign data_wdata = req_wdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign state_dbg  = state_q;

endmodule
